// File: rtl/cpu_package.sv
// Shared fetch-path types: FSM states, instruction width, default reset PC, buffer entry.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package cpu_package;

  localparam int          INSTR_WIDTH      = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // FETCH: request outstanding; FULL: buffer full, no request; DRAIN: waiting to drop a stale response.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; head entry is shown combinationally.
// Latency: a push becomes visible at the head the cycle after it is written.
// Backpressure: push is dropped when full unless a pop frees a slot the same cycle; flush beats push/pop.
module fetch_fifo #(
  parameter int  DEPTH = 2,
  parameter int  WIDTH = 64,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage; flush clears occupancy and discards any same-cycle push.
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requests, small instruction buffer, redirect handling.
// Latency: imem_ack to inst_valid is one cycle; back-to-back requests while the buffer has room.
// Backpressure: inst_ready low fills the buffer, then imem_req drops until decode pops an entry.
module fetch_unit
  import cpu_package::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   inst_valid,
  output logic [INSTR_WIDTH-1:0] inst,
  output logic [31:0]            inst_pc,
  input  logic                   inst_ready
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;       // address of the request in flight (or next to issue)
  logic [31:0]   tgt_q, tgt_d;     // redirect target held while draining a stale response
  logic [31:0]   redirect_tgt;
  logic          buf_push, buf_pop, buf_flush, buf_full, buf_empty;
  logic [CW-1:0] buf_cnt, cnt_after;
  fetch_entry_t  push_entry, head_entry;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign push_entry   = '{pc: pc_q, inst: imem_rdata};
  assign buf_pop      = inst_valid && inst_ready;
  assign buf_flush    = redirect_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (buf_push),
    .push_dat (push_entry),
    .pop      (buf_pop),
    .flush    (buf_flush),
    .head_dat (head_entry),
    .full     (buf_full),
    .empty    (buf_empty),
    .count    (buf_cnt)
  );

  // The request address is the pc register itself, so it cannot move until the ack retires it.
  assign imem_req   = !reset && (state_q != FULL);
  assign imem_addr  = pc_q;
  assign inst_valid = !reset && !buf_empty;
  assign inst       = inst_valid ? head_entry.inst : '0;
  assign inst_pc    = inst_valid ? head_entry.pc   : '0;

  // Next-state, pc and push decisions; a redirect overrides any same-cycle push or pop.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    buf_push  = 1'b0;
    cnt_after = buf_cnt;
    case (state_q)
      FETCH: begin
        if (redirect_valid) begin
          if (imem_ack) begin
            pc_d    = redirect_tgt;
            state_d = FETCH;
          end else begin
            tgt_d   = redirect_tgt;
            state_d = DRAIN;
          end
        end else begin
          if (imem_ack) begin
            buf_push = 1'b1;
            pc_d     = pc_q + 32'd4;
          end
          cnt_after = buf_cnt + CW'(buf_push) - CW'(buf_pop);
          if (cnt_after == CW'(FIFO_DEPTH)) begin
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (redirect_valid) begin
          pc_d    = redirect_tgt;
          state_d = FETCH;
        end else if (buf_pop || !buf_full) begin
          state_d = FETCH;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          tgt_d = redirect_tgt;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_tgt : tgt_q;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // FSM and pc registers; reset abandons any outstanding request and ignores a same-cycle ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule
